lcd_rx: RTL and testbench

- Receiver and checker for the serial-RGB parallel LCD interface driven by the panel timing generator.
- Each pixel is 3 consecutive bytes on lcd_dat, ordered R, G, B, one byte per clk.
- Rebuilds 24-bit pixels with x/y coordinates, detects frame and line boundaries from the syncs, and flags malformed timing.
- Used for loopback capture and self-test of the display path on the badge.

---
 rtl/lcd_rx.sv | 168 ++++++++++++++++
 tb/tb_lcd_rx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rx.sv
// lcd_rx: serial-RGB LCD receiver; rebuilds {R,G,B} pixels with x/y, finds line/frame edges, flags bad timing.
// Latency: pix_valid one clk after the B byte; line_done/frame_done one clk after the causing sample.
// Backpressure: none; the transmitter free-runs and every output is a one-shot strobe or sticky flag.
//
// Ports: clk/resetn (async active-low); lcd_dat/lcd_den/lcd_vsync/lcd_hsync from the panel path
// (den and syncs active low, hsync unused); err_clr clears the sticky errors.
// Outputs: pix_valid/pix_rgb/pix_x/pix_y/frame_start pixel stream, line_done/frame_done pulses,
// locked, err_partial/err_width/err_height sticky flags.
// Optional: define LCD_RX_CRC_EN to add frame_crc, a CRC-16-CCITT of each frame's accepted bytes.
module lcd_rx #(
  parameter int H_VISIBLE = 320,
  parameter int V_VISIBLE = 240
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  lcd_dat,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        lcd_den,
  input  logic        err_clr,
  output logic        pix_valid,
  output logic [23:0] pix_rgb,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        frame_start,
  output logic        line_done,
  output logic        frame_done,
  output logic        locked,
  output logic        err_partial,
  output logic        err_width,
  output logic        err_height
`ifdef LCD_RX_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  typedef enum logic {HUNT, ACTIVE} state_t;

  localparam logic [8:0] H_PIX  = 9'(H_VISIBLE);
  localparam logic [7:0] V_ROWS = 8'(V_VISIBLE);

  state_t     state;
  logic       vsync_q;
  logic [1:0] ch;
  logic [7:0] r_q;
  logic [7:0] g_q;
  logic [8:0] x_cnt;
  logic [7:0] row;
  logic       line_act;   // at least one byte seen since the last line end
  logic       vs_edge;

  // Line timing comes from den alone; hsync is deliberately ignored.
  logic unused_hsync;
  assign unused_hsync = lcd_hsync;

  assign vs_edge = vsync_q & ~lcd_vsync;

`ifdef LCD_RX_CRC_EN
  logic [15:0] crc_run;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] t;
    t = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      t = t[15] ? ((t << 1) ^ 16'h1021) : (t << 1);
    end
    return t;
  endfunction
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= HUNT;
      vsync_q     <= 1'b0;
      ch          <= 2'd0;
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      x_cnt       <= 9'd0;
      row         <= 8'd0;
      line_act    <= 1'b0;
      pix_valid   <= 1'b0;
      pix_rgb     <= 24'd0;
      pix_x       <= 9'd0;
      pix_y       <= 8'd0;
      frame_start <= 1'b0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      locked      <= 1'b0;
      err_partial <= 1'b0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;
`ifdef LCD_RX_CRC_EN
      crc_run     <= 16'hFFFF;
      frame_crc   <= 16'h0000;
`endif
    end else begin
      vsync_q     <= lcd_vsync;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      // Clear first; any error raised below in the same cycle wins.
      if (err_clr) begin
        err_partial <= 1'b0;
        err_width   <= 1'b0;
        err_height  <= 1'b0;
      end

      if (vs_edge) begin
        frame_done <= 1'b1;
        locked     <= 1'b1;
        state      <= ACTIVE;
        row        <= 8'd0;
        x_cnt      <= 9'd0;
        ch         <= 2'd0;
        line_act   <= 1'b0;
`ifdef LCD_RX_CRC_EN
        frame_crc  <= crc_run;
        crc_run    <= 16'hFFFF;
`endif
        // The first boundary after HUNT closes a frame we never watched, so it is not checked.
        if (state == ACTIVE) begin
          if (row != V_ROWS) err_height <= 1'b1;
          if (!lcd_den)      err_partial <= 1'b1;
        end
      end else if (state == ACTIVE) begin
        if (!lcd_den) begin
          line_act <= 1'b1;
`ifdef LCD_RX_CRC_EN
          crc_run  <= crc16_byte(crc_run, lcd_dat);
`endif
          case (ch)
            2'd0: begin
              r_q <= lcd_dat;
              ch  <= 2'd1;
            end
            2'd1: begin
              g_q <= lcd_dat;
              ch  <= 2'd2;
            end
            default: begin
              pix_valid   <= 1'b1;
              pix_rgb     <= {r_q, g_q, lcd_dat};
              pix_x       <= x_cnt;
              pix_y       <= row;
              frame_start <= (x_cnt == 9'd0) && (row == 8'd0);
              x_cnt       <= x_cnt + 9'd1;
              if (x_cnt == 9'd511) err_width <= 1'b1;
              ch          <= 2'd0;
            end
          endcase
        end else begin
          if (ch != 2'd0) err_partial <= 1'b1;
          ch <= 2'd0;
          if (line_act) begin
            line_done <= 1'b1;
            if (x_cnt != H_PIX) err_width <= 1'b1;
            if (row != 8'hFF) row <= row + 8'd1;
            x_cnt    <= 9'd0;
            line_act <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_rx.sv
// tb_lcd_rx: randomized transmitter driving lcd_rx, checked against a frame-level reference model.
// Latency: expected pixels are queued when their B byte is driven and matched on each pix_valid.
// Backpressure: none; stimulus is free-running like the real panel transmitter.
module tb_lcd_rx;
  localparam int H = 32;
  localparam int V = 24;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [7:0]  lcd_dat = 8'd0;
  logic        lcd_hsync = 1'b1;
  logic        lcd_vsync = 1'b1;
  logic        lcd_den = 1'b1;
  logic        err_clr = 1'b0;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        frame_start;
  logic        line_done;
  logic        frame_done;
  logic        locked;
  logic        err_partial;
  logic        err_width;
  logic        err_height;
`ifdef LCD_RX_CRC_EN
  logic [15:0] frame_crc;
`endif

  lcd_rx #(.H_VISIBLE(H), .V_VISIBLE(V)) dut (
    .clk(clk), .resetn(resetn), .lcd_dat(lcd_dat), .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync), .lcd_den(lcd_den), .err_clr(err_clr),
    .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .line_done(line_done), .frame_done(frame_done),
    .locked(locked), .err_partial(err_partial), .err_width(err_width),
    .err_height(err_height)
`ifdef LCD_RX_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: frame-level view of what the receiver should report.
  bit          m_locked = 1'b0;
  int          m_row = 0;
  bit          m_ep = 1'b0, m_ew = 1'b0, m_eh = 1'b0;
  int          exp_ld = 0, exp_fd = 0, exp_fs = 0;
  logic [15:0] m_crc_run = 16'hFFFF;
  logic [15:0] m_frame_crc = 16'h0000;
  logic [41:0] exp_q[$];
  int          got_ld = 0, got_fd = 0, got_fs = 0, got_pv = 0;

  // Bit-serial CRC-16-CCITT, MSB first.
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      got_pv++;
      if (exp_q.size() == 0)
        check_eq("pix_unexpected", 64'(pix_valid), 64'd0);
      else
        check_eq("pix", 64'({frame_start, pix_x, pix_y, pix_rgb}), 64'(exp_q.pop_front()));
    end
    if (line_done === 1'b1)   got_ld++;
    if (frame_done === 1'b1)  got_fd++;
    if (frame_start === 1'b1) got_fs++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      lcd_den   = 1'b1;
      lcd_hsync = 1'($urandom);
      tick();
    end
    lcd_hsync = 1'b1;
  endtask

  task automatic clear_model();
    m_ep = 1'b0;
    m_ew = 1'b0;
    m_eh = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_err_partial"}, 64'(err_partial), 64'(m_ep));
    check_eq({tag, "_err_width"},   64'(err_width),   64'(m_ew));
    check_eq({tag, "_err_height"},  64'(err_height),  64'(m_eh));
    check_eq({tag, "_locked"},      64'(locked),      64'(m_locked));
    check_eq({tag, "_line_done_n"}, 64'(got_ld),      64'(exp_ld));
    check_eq({tag, "_frame_done_n"},64'(got_fd),      64'(exp_fd));
    check_eq({tag, "_frame_start_n"},64'(got_fs),     64'(exp_fs));
    check_eq({tag, "_pix_missing"}, 64'(exp_q.size()),64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    lcd_den = 1'b0;
    lcd_dat = b;
    if (m_locked) m_crc_run = crc_ref(m_crc_run, b);
    tick();
  endtask

  // kind: 0 = pattern {x,y,x^y}, 1 = random, 2 = all zero
  task automatic send_pixels(input int npix, input int kind, input int yl);
    logic [7:0] r, g, b;
    int xe;
    for (int i = 0; i < npix; i++) begin
      case (kind)
        0: begin r = 8'(i); g = 8'(yl); b = 8'(i) ^ 8'(yl); end
        1: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
        default: begin r = 8'd0; g = 8'd0; b = 8'd0; end
      endcase
      send_byte(r);
      send_byte(g);
      if (m_locked) begin
        xe = i % 512;
        if (xe == 0 && m_row == 0) exp_fs++;
        exp_q.push_back({(xe == 0 && m_row == 0), 9'(xe), 8'(m_row), r, g, b});
      end
      send_byte(b);
    end
  endtask

  task automatic send_line(input int npix, input int nextra, input int kind, input bit clr, input int yl);
    send_pixels(npix, kind, yl);
    for (int j = 0; j < nextra; j++) send_byte(8'($urandom));
    lcd_den   = 1'b1;
    lcd_hsync = 1'b0;
    err_clr   = clr;
    if (clr) clear_model();
    if (m_locked && (npix > 0 || nextra > 0)) begin
      exp_ld++;
      if (npix != H) m_ew = 1'b1;
      if (nextra != 0) m_ep = 1'b1;
      if (m_row < 255) m_row++;
    end
    tick();
    err_clr = 1'b0;
    idle(2 + int'($urandom_range(0, 3)));
    check_flags("line");
  endtask

  task automatic vsync_pulse(input bit clr, input bit den_low);
    lcd_vsync = 1'b0;
    err_clr   = clr;
    if (den_low) begin
      lcd_den = 1'b0;
      lcd_dat = 8'($urandom);
    end
    if (clr) clear_model();
    exp_fd++;
    if (m_locked) begin
      if (m_row != V) m_eh = 1'b1;
      if (den_low) m_ep = 1'b1;
    end
    m_frame_crc = m_crc_run;
    m_crc_run   = 16'hFFFF;
    m_locked    = 1'b1;
    m_row       = 0;
    tick();
    lcd_den = 1'b1;
    err_clr = 1'b0;
    tick();
    lcd_vsync = 1'b1;
    idle(3);
    check_flags("vsync");
`ifdef LCD_RX_CRC_EN
    check_eq("frame_crc", 64'(frame_crc), 64'(m_frame_crc));
`endif
  endtask

  task automatic send_frame(input int nlines, input int kind);
    for (int l = 0; l < nlines; l++) send_line(H, 0, kind, 1'b0, l);
  endtask

  task automatic do_reset();
    check_eq("q_before_reset", 64'(exp_q.size()), 64'd0);
    resetn      = 1'b0;
    lcd_den     = 1'b1;
    lcd_vsync   = 1'b1;
    err_clr     = 1'b0;
    m_locked    = 1'b0;
    m_row       = 0;
    clear_model();
    m_crc_run   = 16'hFFFF;
    m_frame_crc = 16'h0000;
    exp_q.delete();
    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_pix_valid", 64'(pix_valid), 64'd0);
    check_eq("rst_pix_rgb",   64'(pix_rgb),   64'd0);
    check_eq("rst_pix_xy",    64'({pix_x, pix_y}), 64'd0);
    check_eq("rst_strobes",   64'({frame_start, line_done, frame_done}), 64'd0);
    check_eq("rst_locked",    64'(locked),    64'd0);
    check_eq("rst_errors",    64'({err_partial, err_width, err_height}), 64'd0);
`ifdef LCD_RX_CRC_EN
    check_eq("rst_frame_crc", 64'(frame_crc), 64'(m_frame_crc));
`endif
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    int pv0;
    #1;
    do_reset();

    // Frame 1 arrives before any boundary and must be ignored; frame 2 is fully decoded.
    send_frame(V, 0);
    vsync_pulse(1'b0, 1'b0);
    pv0 = got_pv;
    send_frame(V, 0);
    vsync_pulse(1'b0, 1'b0);
    check_eq("frame2_pix_count", 64'(got_pv - pv0), 64'(H * V));

    // Reset in the middle of a line, then re-acquire.
    send_pixels(10, 1, 0);
    send_byte(8'($urandom));
    do_reset();
    for (int l = 0; l < 3; l++) send_line(H, 0, 1, 1'b0, l);
    vsync_pulse(1'b0, 1'b0);
    send_frame(V, 1);
    vsync_pulse(1'b0, 1'b0);

    // Width, partial-pixel and x-wrap errors with err_clr on clean lines.
    send_line(H - 1, 0, 1, 1'b0, 0);
    send_line(H, 0, 1, 1'b1, 0);
    send_line(5, 2, 1, 1'b0, 0);
    send_line(H, 0, 1, 1'b0, 0);
    send_line(H, 0, 1, 1'b1, 0);
    send_line(514, 0, 1, 1'b0, 0);
    send_line(H, 0, 1, 1'b1, 0);
    for (int l = 7; l < V - 1; l++) send_line(H, 0, 1, 1'b0, l);
    vsync_pulse(1'b0, 1'b0);

    // Second bad boundary coinciding with err_clr keeps err_height.
    send_frame(V - 2, 1);
    vsync_pulse(1'b1, 1'b0);

    // Good height but a byte lands on the boundary cycle.
    send_frame(V, 1);
    vsync_pulse(1'b0, 1'b1);

    err_clr = 1'b1;
    lcd_den = 1'b1;
    clear_model();
    tick();
    err_clr = 1'b0;
    idle(2);
    check_flags("clr");

    // Constant-black frame; frame_crc is compared at the closing boundary.
    send_frame(V, 2);
    vsync_pulse(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
